cram_writer: RTL and testbench

Write-side front end for the 256×15 palette RAM (CRAM) used by the video output stage. It collects Z80 byte writes to the palette window and DMA word writes. Each 15-bit entry passes through a 4-deep ordered FIFO. The block emits single-cycle `cram_we` pulses with registered address and data, and never loses an accepted DMA word.

---
 rtl/cram_writer.sv | 55 +++++
 tb/tb_cram_writer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cram_writer.sv
// cram_writer: Z80/DMA palette writes queued through a 4-deep FIFO into registered CRAM write pulses
module cram_writer (
  input  logic        clk,
  input  logic        rst,
  input  logic        zwe,
  input  logic [8:0]  zaddr,
  input  logic [7:0]  zdata,
  input  logic        dma_req,
  input  logic [7:0]  dma_addr,
  input  logic [15:0] dma_data,
  output logic        dma_rdy,
  input  logic        wr_en,
  output logic [7:0]  cram_addr,
  output logic [14:0] cram_data,
  output logic        cram_we,
  output logic        ovf
);
  logic [22:0] mem [4];
  logic [1:0]  wp, rp;
  logic [2:0]  count;
  logic [7:0]  lo_reg;
  logic        z_commit, z_push, dma_push, push, pop;
  logic [22:0] din;
  // DMA may fill at most two slots so the other two stay free for unstallable Z80 commits
  always_comb begin
    z_commit = zwe && zaddr[0];
    dma_rdy  = count < 3'd2 && !z_commit;
    z_push   = z_commit && count != 3'd4;
    dma_push = dma_req && dma_rdy;
    push     = z_push || dma_push;
    pop      = count != 3'd0 && wr_en;
    din      = z_commit ? {zaddr[8:1], zdata[6:0], lo_reg} : {dma_addr, dma_data[14:0]};
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      lo_reg    <= '0;
      cram_we   <= 1'b0;
      cram_addr <= '0;
      cram_data <= '0;
      ovf       <= 1'b0;
    end else begin
      if (zwe && !zaddr[0]) lo_reg <= zdata;
      if (push) wp <= wp + 2'd1;
      if (pop) rp <= rp + 2'd1;
      count   <= count + 3'(push) - 3'(pop);
      cram_we <= pop;
      if (pop) {cram_addr, cram_data} <= mem[rp];
      if (z_commit && count == 3'd4) ovf <= 1'b1;
    end
endmodule

// File: tb/tb_cram_writer.sv
// tb_cram_writer: directed scenario tests for cram_writer
module tb_cram_writer;
  logic clk = 0, rst = 1, zwe = 0, dma_req = 0, wr_en = 0;
  logic [8:0] zaddr = 0;
  logic [7:0] zdata = 0, dma_addr = 0;
  logic [15:0] dma_data = 0;
  logic dma_rdy, cram_we, ovf;
  logic [7:0] cram_addr;
  logic [14:0] cram_data;
  int errs = 0, chks = 0, cyc = 0;
  logic [7:0] la[$];
  logic [14:0] ld[$];
  int lc[$];

  cram_writer dut (.clk(clk), .rst(rst), .zwe(zwe), .zaddr(zaddr), .zdata(zdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_data(dma_data), .dma_rdy(dma_rdy),
    .wr_en(wr_en), .cram_addr(cram_addr), .cram_data(cram_data), .cram_we(cram_we), .ovf(ovf));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cram_we) begin la.push_back(cram_addr); ld.push_back(cram_data); lc.push_back(cyc); end

  task automatic z_wr(input logic [8:0] a, input logic [7:0] d);
    @(negedge clk); zwe = 1; zaddr = a; zdata = d;
    @(posedge clk); #1 zwe = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log;
    la.delete(); ld.delete(); lc.delete();
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    chks++; if (cram_we !== 1'b0) begin errs++; $display("FAIL reset_we got %b exp 0", cram_we); end
    chks++; if (cram_addr !== 8'h00) begin errs++; $display("FAIL reset_addr got %h exp 00", cram_addr); end
    chks++; if (cram_data !== 15'h0) begin errs++; $display("FAIL reset_data got %h exp 0000", cram_data); end
    chks++; if (ovf !== 1'b0) begin errs++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    chks++; if (dma_rdy !== 1'b1) begin errs++; $display("FAIL reset_rdy got %b exp 1", dma_rdy); end
    rst = 0;
  endtask

  task automatic test_z80_pair;
    int e;
    wr_en = 1; clear_log();
    z_wr(9'h0A0, 8'h34);
    z_wr(9'h0A1, 8'h92);
    e = cyc;
    idle(5);
    chks++; if (la.size() !== 1) begin errs++; $display("FAIL pair_count got %0d exp 1", la.size()); end
    if (la.size() == 1) begin
      chks++; if (la[0] !== 8'h50) begin errs++; $display("FAIL pair_addr got %h exp 50", la[0]); end
      chks++; if (ld[0] !== 15'h1234) begin errs++; $display("FAIL pair_data got %h exp 1234", ld[0]); end
      chks++; if (lc[0] !== e + 1) begin errs++; $display("FAIL pair_latency got %0d exp %0d", lc[0], e + 1); end
    end
  endtask

  task automatic test_dma_burst;
    int n = 0, g = 0;
    logic acc;
    wr_en = 1; clear_log();
    while (n < 8 && g < 40) begin
      @(negedge clk); dma_req = 1; dma_addr = 8'(n); dma_data = 16'h8000 | 16'(n);
      #1 acc = dma_rdy;
      @(posedge clk); g++;
      if (acc) n++;
    end
    @(negedge clk); dma_req = 0;
    idle(6);
    chks++; if (n !== 8) begin errs++; $display("FAIL burst_accept got %0d exp 8", n); end
    chks++; if (la.size() !== 8) begin errs++; $display("FAIL burst_count got %0d exp 8", la.size()); end
    for (int i = 0; i < 8 && i < la.size(); i++) begin
      chks++; if (la[i] !== 8'(i) || ld[i] !== 15'(i)) begin errs++; $display("FAIL burst_entry%0d got %h/%h exp %h/%h", i, la[i], ld[i], 8'(i), 15'(i)); end
      chks++; if (lc[i] !== lc[0] + i) begin errs++; $display("FAIL burst_gap%0d got %0d exp %0d", i, lc[i], lc[0] + i); end
    end
  endtask

  task automatic test_stall_reserve;
    int n = 0;
    logic acc;
    wr_en = 0; clear_log();
    repeat (6) begin
      @(negedge clk); dma_req = 1; dma_addr = 8'h10 + 8'(n); dma_data = 16'h0100 + 16'(n);
      #1 acc = dma_rdy;
      @(posedge clk);
      if (acc) n++;
    end
    @(negedge clk); dma_req = 0; #1;
    chks++; if (n !== 2) begin errs++; $display("FAIL stall_accept got %0d exp 2", n); end
    chks++; if (dma_rdy !== 1'b0) begin errs++; $display("FAIL stall_rdy got %b exp 0", dma_rdy); end
    z_wr(9'h041, 8'h05);
    z_wr(9'h043, 8'hFF);
    @(negedge clk);
    chks++; if (ovf !== 1'b0) begin errs++; $display("FAIL stall_ovf got %b exp 0", ovf); end
    chks++; if (la.size() !== 0) begin errs++; $display("FAIL stall_nowrite got %0d exp 0", la.size()); end
    wr_en = 1;
    idle(7);
    chks++; if (la.size() !== 4) begin errs++; $display("FAIL stall_count got %0d exp 4", la.size()); end
    if (la.size() == 4) begin
      chks++; if (la[0] !== 8'h10 || ld[0] !== 15'h0100) begin errs++; $display("FAIL stall_e0 got %h/%h exp 10/0100", la[0], ld[0]); end
      chks++; if (la[1] !== 8'h11 || ld[1] !== 15'h0101) begin errs++; $display("FAIL stall_e1 got %h/%h exp 11/0101", la[1], ld[1]); end
      chks++; if (la[2] !== 8'h20 || ld[2] !== 15'h0534) begin errs++; $display("FAIL stall_e2 got %h/%h exp 20/0534", la[2], ld[2]); end
      chks++; if (la[3] !== 8'h21 || ld[3] !== 15'h7F34) begin errs++; $display("FAIL stall_e3 got %h/%h exp 21/7f34", la[3], ld[3]); end
    end
  endtask

  task automatic test_collision;
    wr_en = 1; clear_log();
    @(negedge clk); zwe = 1; zaddr = 9'h061; zdata = 8'h01;
    dma_req = 1; dma_addr = 8'h31; dma_data = 16'hC321;
    #1;
    chks++; if (dma_rdy !== 1'b0) begin errs++; $display("FAIL coll_rdy_low got %b exp 0", dma_rdy); end
    @(negedge clk); zwe = 0; #1;
    chks++; if (dma_rdy !== 1'b1) begin errs++; $display("FAIL coll_rdy_high got %b exp 1", dma_rdy); end
    @(negedge clk); dma_req = 0;
    idle(5);
    chks++; if (la.size() !== 2) begin errs++; $display("FAIL coll_count got %0d exp 2", la.size()); end
    if (la.size() == 2) begin
      chks++; if (la[0] !== 8'h30 || ld[0] !== 15'h0134) begin errs++; $display("FAIL coll_first got %h/%h exp 30/0134", la[0], ld[0]); end
      chks++; if (la[1] !== 8'h31 || ld[1] !== 15'h4321) begin errs++; $display("FAIL coll_second got %h/%h exp 31/4321", la[1], ld[1]); end
    end
  endtask

  task automatic test_overflow;
    wr_en = 0; clear_log();
    z_wr(9'h000, 8'hAB);
    for (int i = 0; i < 4; i++) z_wr({8'h40 + 8'(i), 1'b1}, 8'h40 + 8'(i));
    @(negedge clk); #1;
    chks++; if (ovf !== 1'b0) begin errs++; $display("FAIL ovf_before got %b exp 0", ovf); end
    chks++; if (dma_rdy !== 1'b0) begin errs++; $display("FAIL ovf_rdy got %b exp 0", dma_rdy); end
    zwe = 1; zaddr = 9'h089; zdata = 8'h55; wr_en = 1;
    @(posedge clk); #1 zwe = 0;
    @(negedge clk);
    chks++; if (ovf !== 1'b1) begin errs++; $display("FAIL ovf_set got %b exp 1", ovf); end
    idle(7);
    chks++; if (la.size() !== 4) begin errs++; $display("FAIL ovf_count got %0d exp 4", la.size()); end
    for (int i = 0; i < 4 && i < la.size(); i++) begin
      chks++; if (la[i] !== 8'h40 + 8'(i) || ld[i] !== {7'h40 + 7'(i), 8'hAB}) begin errs++; $display("FAIL ovf_e%0d got %h/%h exp %h/%h", i, la[i], ld[i], 8'h40 + 8'(i), {7'h40 + 7'(i), 8'hAB}); end
    end
    chks++; if (ovf !== 1'b1) begin errs++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
  endtask

  task automatic test_reset_mid;
    wr_en = 0;
    for (int i = 0; i < 3; i++) z_wr({8'h70 + 8'(i), 1'b1}, 8'h11);
    @(negedge clk); wr_en = 1;
    @(posedge clk); #2 rst = 1; #1;
    chks++; if (cram_we !== 1'b0) begin errs++; $display("FAIL rmid_we got %b exp 0", cram_we); end
    chks++; if (dma_rdy !== 1'b1) begin errs++; $display("FAIL rmid_rdy got %b exp 1", dma_rdy); end
    chks++; if (ovf !== 1'b0) begin errs++; $display("FAIL rmid_ovf got %b exp 0", ovf); end
    @(negedge clk); rst = 0; clear_log();
    idle(6);
    chks++; if (la.size() !== 0) begin errs++; $display("FAIL rmid_nopulse got %0d exp 0", la.size()); end
    chks++; if (dma_rdy !== 1'b1) begin errs++; $display("FAIL rmid_rdy_after got %b exp 1", dma_rdy); end
  endtask

  initial begin
    test_reset();
    test_z80_pair();
    test_dma_burst();
    test_stall_reserve();
    test_collision();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
